knight_rider_sequencer: RTL and testbench



---
 rtl/knight_rider_pkg.sv | 16 +
 rtl/knight_rider_sequencer_rate_prescaler.sv | 55 +++++
 rtl/knight_rider_sequencer.sv | 151 +++++++++++++++
 tb/tb_knight_rider_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/knight_rider_pkg.sv
// Shared definitions for the LED scanner: FSM state codes and prescaler sizing.
package knight_rider_pkg;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StScanUp  = 3'd1;
  localparam logic [2:0] StDwellHi = 3'd2;
  localparam logic [2:0] StScanDn  = 3'd3;
  localparam logic [2:0] StDwellLo = 3'd4;

  // Wide enough to count to 2^(base_shift + max speed) - 1.
  function automatic int unsigned prescale_width(input int unsigned base_shift,
                                                 input int unsigned speed_w);
    return base_shift + (1 << speed_w) - 1;
  endfunction

endpackage

// File: rtl/knight_rider_sequencer_rate_prescaler.sv
// Power-of-two tick prescaler with a speed latch that only updates at period boundaries.
module rate_prescaler
  import knight_rider_pkg::*;
#(
  parameter int unsigned BASE_SHIFT = 2,
  parameter int unsigned SPEED_W    = 3
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               run,
  input  logic               start,
  input  logic               hold,
  input  logic [SPEED_W-1:0] speed,
  output logic               tick
);

  localparam int unsigned CW = prescale_width(BASE_SHIFT, SPEED_W);
  localparam logic [CW:0] OneWide = 1;

  logic [CW-1:0]      count_q, count_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [CW:0]        period;
  logic [CW-1:0]      last;

  always_comb begin
    period = OneWide << (BASE_SHIFT + 32'(speed_q));
    last   = CW'(period - OneWide);
    tick   = run && !hold && (count_q == last);
  end

  always_comb begin
    count_d = count_q;
    speed_d = speed_q;
    if (!run) begin
      count_d = '0;
    end else if (!hold) begin
      count_d = tick ? '0 : count_q + CW'(1);
    end
    // Latching only here keeps a mid-period speed change from bending the current period.
    if (start || tick) begin
      speed_d = speed;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      count_q <= '0;
      speed_q <= '0;
    end else begin
      count_q <= count_d;
      speed_q <= speed_d;
    end
  end

endmodule

// File: rtl/knight_rider_sequencer.sv
// LED scanner sequencer: sweeps a single lit LED up and down the bar, dwelling at each end.
module knight_rider_sequencer
  import knight_rider_pkg::*;
#(
  parameter int unsigned N_LEDS      = 8,
  parameter int unsigned BASE_SHIFT  = 2,
  parameter int unsigned SPEED_W     = 3,
  parameter int unsigned DWELL_TICKS = 2
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      hold,
  input  logic [SPEED_W-1:0]        speed,
  output logic [N_LEDS-1:0]         leds,
  output logic [$clog2(N_LEDS)-1:0] pos,
  output logic                      dir_up,
  output logic                      tick
);

  localparam int unsigned POS_W = $clog2(N_LEDS);
  localparam logic [POS_W-1:0] PosMax = POS_W'(N_LEDS - 1);
  localparam logic [3:0] DwellInit = 4'(DWELL_TICKS - 1);
  localparam logic [N_LEDS-1:0] LedOne = 1;

  if (N_LEDS < 2 || N_LEDS > 32) begin : gen_bad_n_leds
    $error("knight_rider_sequencer: N_LEDS must be 2..32");
  end
  if (DWELL_TICKS < 1 || DWELL_TICKS > 15) begin : gen_bad_dwell
    $error("knight_rider_sequencer: DWELL_TICKS must be 1..15");
  end

  logic [2:0]        state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              dir_up_q, dir_up_d;
  logic [3:0]        dwell_q, dwell_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic              run, start;

  assign run   = (state_q != StIdle);
  assign start = (state_q == StIdle) && enable && !hold;

  rate_prescaler #(
    .BASE_SHIFT (BASE_SHIFT),
    .SPEED_W    (SPEED_W)
  ) u_prescaler (
    .clk_in (clk_in),
    .reset  (reset),
    .run    (run),
    .start  (start),
    .hold   (hold),
    .speed  (speed),
    .tick   (tick)
  );

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dir_up_d = dir_up_q;
    dwell_d  = dwell_q;
    // Dropping enable wins even while held.
    if (!enable) begin
      state_d  = StIdle;
      pos_d    = '0;
      dir_up_d = 1'b1;
      dwell_d  = '0;
    end else if (!hold) begin
      case (state_q)
        StIdle: begin
          state_d  = StScanUp;
          pos_d    = '0;
          dir_up_d = 1'b1;
        end
        StScanUp: begin
          if (tick) begin
            if (pos_q < PosMax) begin
              pos_d = pos_q + POS_W'(1);
            end else begin
              state_d = StDwellHi;
              dwell_d = DwellInit;
            end
          end
        end
        StDwellHi: begin
          if (tick) begin
            if (dwell_q == '0) begin
              state_d  = StScanDn;
              dir_up_d = 1'b0;
              pos_d    = pos_q - POS_W'(1);
            end else begin
              dwell_d = dwell_q - 4'd1;
            end
          end
        end
        StScanDn: begin
          if (tick) begin
            if (pos_q > '0) begin
              pos_d = pos_q - POS_W'(1);
            end else begin
              state_d = StDwellLo;
              dwell_d = DwellInit;
            end
          end
        end
        StDwellLo: begin
          if (tick) begin
            if (dwell_q == '0) begin
              state_d  = StScanUp;
              dir_up_d = 1'b1;
              pos_d    = pos_q + POS_W'(1);
            end else begin
              dwell_d = dwell_q - 4'd1;
            end
          end
        end
        default: begin
          state_d  = StIdle;
          pos_d    = '0;
          dir_up_d = 1'b1;
          dwell_d  = '0;
        end
      endcase
    end
  end

  // Decoding from next-state keeps leds aligned with pos on the same edge.
  always_comb begin
    leds_d = (state_d == StIdle) ? '0 : (LedOne << pos_d);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= StIdle;
      pos_q    <= '0;
      dir_up_q <= 1'b1;
      dwell_q  <= '0;
      leds_q   <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dir_up_q <= dir_up_d;
      dwell_q  <= dwell_d;
      leds_q   <= leds_d;
    end
  end

  assign leds   = leds_q;
  assign pos    = pos_q;
  assign dir_up = dir_up_q;

endmodule

// File: tb/tb_knight_rider_sequencer.sv
// Directed bench for knight_rider_sequencer with a tick-count based reference model.
module tb_knight_rider_sequencer;

  localparam int N_LEDS      = 8;
  localparam int BASE_SHIFT  = 2;
  localparam int SPEED_W     = 3;
  localparam int DWELL_TICKS = 2;
  localparam int ROUND       = 2 * (N_LEDS - 1) + 2 * DWELL_TICKS;

  logic              clk_in = 1'b0;
  logic              reset;
  logic              enable;
  logic              hold;
  logic [SPEED_W-1:0] speed;
  logic [N_LEDS-1:0] leds;
  logic [2:0]        pos;
  logic              dir_up;
  logic              tick;

  int tests = 0;
  int fails = 0;
  int rel   = 0;
  bit chk_en = 1'b0;

  always #5 clk_in = ~clk_in;

  knight_rider_sequencer #(
    .N_LEDS      (N_LEDS),
    .BASE_SHIFT  (BASE_SHIFT),
    .SPEED_W     (SPEED_W),
    .DWELL_TICKS (DWELL_TICKS)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .enable (enable),
    .hold   (hold),
    .speed  (speed),
    .leds   (leds),
    .pos    (pos),
    .dir_up (dir_up),
    .tick   (tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Position after t ticks of a run: the sweep repeats every ROUND ticks after the first.
  function automatic int exp_pos(input int t);
    int m;
    if (t == 0) return 0;
    m = ((t - 1) % ROUND) + 1;
    if (m <= N_LEDS - 1) return m;
    if (m <= N_LEDS - 1 + DWELL_TICKS) return N_LEDS - 1;
    if (m <= 2 * (N_LEDS - 1) + DWELL_TICKS) return N_LEDS - 1 - (m - (N_LEDS - 1 + DWELL_TICKS));
    return 0;
  endfunction

  function automatic bit exp_up(input int t);
    int m;
    if (t == 0) return 1'b1;
    m = ((t - 1) % ROUND) + 1;
    return m <= N_LEDS - 1 + DWELL_TICKS;
  endfunction

  bit m_run   = 1'b0;
  int m_ticks = 0;
  int m_cnt   = 0;
  int m_speed = 0;

  always @(posedge clk_in) begin
    if (reset) begin
      m_run = 1'b0; m_ticks = 0; m_cnt = 0; m_speed = 0;
    end else if (!enable) begin
      m_run = 1'b0; m_ticks = 0; m_cnt = 0;
    end else if (hold) begin
      m_cnt = m_cnt;
    end else if (!m_run) begin
      m_run = 1'b1; m_ticks = 0; m_cnt = 0; m_speed = int'(speed);
    end else if (m_cnt == (1 << (BASE_SHIFT + m_speed)) - 1) begin
      m_cnt = 0; m_ticks++; m_speed = int'(speed);
    end else begin
      m_cnt++;
    end
  end

  always @(posedge clk_in) begin
    #1;
    if (chk_en) begin
      check("model_leds", 32'(leds), m_run ? (32'd1 << exp_pos(m_ticks)) : 32'd0);
      check("model_pos", 32'(pos), m_run ? 32'(exp_pos(m_ticks)) : 32'd0);
      check("model_dir", 32'(dir_up), m_run ? 32'(exp_up(m_ticks)) : 32'd1);
      check("model_tick", 32'(tick),
            32'(m_run && !hold && (m_cnt == (1 << (BASE_SHIFT + m_speed)) - 1)));
    end
  end

  task automatic at(input int j);
    while (rel < j) begin
      @(negedge clk_in);
      rel++;
    end
  endtask

  task automatic lit(input string name, input logic [7:0] l, input logic [2:0] p, input logic d);
    check({name, "_leds"}, 32'(leds), 32'(l));
    check({name, "_pos"}, 32'(pos), 32'(p));
    check({name, "_dir"}, 32'(dir_up), 32'(d));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; hold = 1'b0; speed = '0;
    repeat (3) @(negedge clk_in);
    reset  = 1'b0;
    chk_en = 1'b1;
    lit("reset", 8'h00, 3'd0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      check("idle_tick", 32'(tick), 32'd0);
    end
    lit("idle", 8'h00, 3'd0, 1'b1);

    // Full sweep at the fastest rate, edge k is rel 0.
    enable = 1'b1;
    @(negedge clk_in);
    rel = 0;
    lit("k0", 8'h01, 3'd0, 1'b1);
    at(4);  lit("k4", 8'h02, 3'd1, 1'b1);
    at(8);  lit("k8", 8'h04, 3'd2, 1'b1);
    at(28); lit("k28", 8'h80, 3'd7, 1'b1);
    at(36); lit("k36", 8'h80, 3'd7, 1'b1);
    at(40); lit("k40", 8'h40, 3'd6, 1'b0);
    at(64); lit("k64", 8'h01, 3'd0, 1'b0);
    at(68); lit("k68", 8'h01, 3'd0, 1'b0);
    at(76); lit("k76", 8'h02, 3'd1, 1'b1);

    // Slow rate, then a mid-period speed change that must not cut the period short.
    speed = 3'd3;
    at(80);  lit("slow80", 8'h04, 3'd2, 1'b1);
    at(90);  speed = 3'd0;
    at(100); lit("slow100", 8'h04, 3'd2, 1'b1);
    at(110); check("slow_tick110", 32'(tick), 32'd0);
    at(111); check("slow_tick111", 32'(tick), 32'd1);
    at(112); lit("k112", 8'h08, 3'd3, 1'b1);

    // Hold for 20 edges at pos 3.
    at(113); hold = 1'b1;
    at(120); check("hold_tick", 32'(tick), 32'd0); lit("hold120", 8'h08, 3'd3, 1'b1);
    at(133); lit("hold133", 8'h08, 3'd3, 1'b1); hold = 1'b0;
    at(134); check("rel_tick134", 32'(tick), 32'd0);
    at(135); check("rel_tick135", 32'(tick), 32'd1);
    at(136); lit("k136", 8'h10, 3'd4, 1'b1);
    at(139); check("rel_tick139", 32'(tick), 32'd1);
    at(140); lit("k140", 8'h20, 3'd5, 1'b1);

    // Enable dropped mid-dwell, then restarted.
    at(153); lit("dwell153", 8'h80, 3'd7, 1'b1); enable = 1'b0;
    at(154); lit("drop154", 8'h00, 3'd0, 1'b1);
    at(158); enable = 1'b1;
    at(159); lit("restart159", 8'h01, 3'd0, 1'b1);

    // Reset while scanning down at pos 5.
    at(203); lit("dn203", 8'h20, 3'd5, 1'b0);
    at(204); reset = 1'b1;
    at(205); lit("rst205", 8'h00, 3'd0, 1'b1); check("rst_tick", 32'(tick), 32'd0);
    reset = 1'b0;
    at(206); lit("after_rst206", 8'h01, 3'd0, 1'b1);
    at(210); lit("after_rst210", 8'h02, 3'd1, 1'b1);
    at(230);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
